// File: rtl/uart_out_if.sv
// Byte handshake between a byte source and the uart_out transmitter.
interface uart_out_if;
   logic [7:0] byte_in;
   logic       valid;
   logic       ready;

   modport master (output byte_in, output valid, input ready);
   modport slave  (input byte_in, input valid, output ready);
endinterface

// File: rtl/uart_out.sv
// uart_out: FIFO-buffered UART transmitter sending LSB-first 8N1 frames on uart_tx.
// Define UART_OUT_PARITY_EN to add a parity bit after the data (PARITY_ODD selects odd).
module uart_out #(
   parameter int CLK_HZ     = 27000000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 4,
   parameter int STOP_BITS  = 1
`ifdef UART_OUT_PARITY_EN
   ,
   parameter int PARITY_ODD = 0
`endif
) (
   input  logic                        clk,
   input  logic                        rst,
   uart_out_if.slave                   bus,
   output logic                        uart_tx,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] level
);
   localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam int PW           = $clog2(FIFO_DEPTH);
   localparam int LW           = PW + 1;
   localparam int STOP_CLKS    = STOP_BITS * CLKS_PER_BIT;
   localparam int CW           = $clog2(STOP_CLKS + 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] STOP_LAST = CW'(STOP_CLKS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
`ifdef UART_OUT_PARITY_EN
      ,
      S_PARITY
`endif
   } state_t;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_reg;
   logic [PW-1:0] rd_ptr_reg;
   logic [LW-1:0] level_reg;
   logic          push;
   logic          pop;
   logic          empty;
   logic          full;
   logic [7:0]    head;

   state_t        state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [2:0]    idx_reg, idx_next;
   logic [7:0]    shift_reg, shift_next;
   logic          tx_reg, tx_next;
`ifdef UART_OUT_PARITY_EN
   logic          parity_reg, parity_next;
   logic          head_parity;

   assign head_parity = (PARITY_ODD != 0) ? ~^head : ^head;
`endif

   assign empty     = (level_reg == '0);
   assign full      = (level_reg == LW'(FIFO_DEPTH));
   assign bus.ready = !full && !rst;
   assign push      = bus.valid && bus.ready;
   assign head      = mem[rd_ptr_reg];

   assign uart_tx = tx_reg;
   assign busy    = (state_reg != S_IDLE) || !empty;
   assign level   = level_reg;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= bus.byte_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         if (push && !pop) begin
            level_reg <= level_reg + 1'b1;
         end else if (!push && pop) begin
            level_reg <= level_reg - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= S_IDLE;
         cnt_reg    <= '0;
         idx_reg    <= '0;
         shift_reg  <= '0;
         tx_reg     <= 1'b1;
`ifdef UART_OUT_PARITY_EN
         parity_reg <= 1'b0;
`endif
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         idx_reg    <= idx_next;
         shift_reg  <= shift_next;
         tx_reg     <= tx_next;
`ifdef UART_OUT_PARITY_EN
         parity_reg <= parity_next;
`endif
      end
   end

   // tx_next is the level the line takes after this edge, so every state
   // transition also loads the first bit of the state being entered.
   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg + 1'b1;
      idx_next    = idx_reg;
      shift_next  = shift_reg;
      tx_next     = tx_reg;
      pop         = 1'b0;
`ifdef UART_OUT_PARITY_EN
      parity_next = parity_reg;
`endif
      case (state_reg)
         S_IDLE: begin
            tx_next  = 1'b1;
            cnt_next = '0;
            if (!empty) begin
               pop         = 1'b1;
               shift_next  = head;
               tx_next     = 1'b0;
               state_next  = S_START;
`ifdef UART_OUT_PARITY_EN
               parity_next = head_parity;
`endif
            end
         end
         S_START: begin
            if (cnt_reg == BIT_LAST) begin
               cnt_next   = '0;
               idx_next   = '0;
               tx_next    = shift_reg[0];
               state_next = S_DATA;
            end
         end
         S_DATA: begin
            if (cnt_reg == BIT_LAST) begin
               cnt_next = '0;
               if (idx_reg == 3'd7) begin
`ifdef UART_OUT_PARITY_EN
                  tx_next    = parity_reg;
                  state_next = S_PARITY;
`else
                  tx_next    = 1'b1;
                  state_next = S_STOP;
`endif
               end else begin
                  idx_next   = idx_reg + 1'b1;
                  shift_next = {1'b0, shift_reg[7:1]};
                  tx_next    = shift_reg[1];
               end
            end
         end
`ifdef UART_OUT_PARITY_EN
         S_PARITY: begin
            if (cnt_reg == BIT_LAST) begin
               cnt_next   = '0;
               tx_next    = 1'b1;
               state_next = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (cnt_reg == STOP_LAST) begin
               cnt_next = '0;
               // Chain straight into the next start bit so queued frames have no gap.
               if (!empty) begin
                  pop         = 1'b1;
                  shift_next  = head;
                  tx_next     = 1'b0;
                  state_next  = S_START;
`ifdef UART_OUT_PARITY_EN
                  parity_next = head_parity;
`endif
               end else begin
                  tx_next    = 1'b1;
                  state_next = S_IDLE;
               end
            end
         end
         default: begin
            cnt_next   = '0;
            tx_next    = 1'b1;
            state_next = S_IDLE;
         end
      endcase
   end
endmodule

// File: tb/tb_uart_out.sv
// Self-checking bench for uart_out: directed frames plus random bytes checked
// against a frame-level waveform model and a serial receiver with a scoreboard.
module tb_uart_out;
   localparam int CLK_HZ     = 1600;
   localparam int BAUD       = 100;
   localparam int FIFO_DEPTH = 4;
   localparam int STOP_BITS  = 1;
   localparam int CPB        = CLK_HZ / BAUD;
`ifdef UART_OUT_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int FRAME_BITS = 10 + PAR + STOP_BITS - 1;
   localparam int FRAME_CLKS = FRAME_BITS * CPB;
   localparam int LIMIT      = 20000;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       uart_tx;
   logic       busy;
   logic [2:0] level;

   uart_out_if bus ();

   uart_out #(
      .CLK_HZ    (CLK_HZ),
      .BAUD      (BAUD),
      .FIFO_DEPTH(FIFO_DEPTH),
      .STOP_BITS (STOP_BITS)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .bus    (bus),
      .uart_tx(uart_tx),
      .busy   (busy),
      .level  (level)
   );

   always #5 clk = ~clk;

   int cyc       = 0;
   int rst_epoch = 0;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) rst_epoch <= rst_epoch + 1;
   end

   int         total = 0;
   int         bad   = 0;
   logic [7:0] exp_q[$];
   logic [7:0] rx_q[$];
   int         rx_start[$];
   logic       rx_active = 1'b0;
   logic       mon_en    = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Ideal line level during bit slot k of a frame carrying d.
   function automatic logic frame_bit(input logic [7:0] d, input int k);
      if (k == 0) return 1'b0;
      if (k <= 8) return d[k-1];
`ifdef UART_OUT_PARITY_EN
      if (k == 9) return ^d;
`endif
      return 1'b1;
   endfunction

   // Serial receiver: mid-bit sampling; frames cut short by a reset are dropped.
   int         m_t0;
   int         m_ep;
   logic [7:0] m_d;
   logic       m_start;
   logic       m_stop;
   logic       m_par;
   initial begin : rx_mon
      forever begin
         @(negedge clk);
         if (mon_en && !rst && uart_tx === 1'b0) begin
            rx_active = 1'b1;
            m_t0 = cyc;
            m_ep = rst_epoch;
            repeat (CPB / 2) @(negedge clk);
            m_start = uart_tx;
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               m_d[i] = uart_tx;
            end
            m_par = 1'b0;
`ifdef UART_OUT_PARITY_EN
            repeat (CPB) @(negedge clk);
            m_par = uart_tx;
`endif
            repeat (CPB) @(negedge clk);
            m_stop = uart_tx;
            if (rst_epoch == m_ep) begin
               check("rx_start_bit", m_start, 1'b0);
               check("rx_stop_bit", m_stop, 1'b1);
`ifdef UART_OUT_PARITY_EN
               check("rx_parity_bit", m_par, ^m_d);
`endif
               rx_q.push_back(m_d);
               rx_start.push_back(m_t0);
            end
            rx_active = 1'b0;
         end
      end
   end

   task automatic push(input logic [7:0] d, output int edge_n);
      int n = 0;
      @(negedge clk);
      bus.byte_in = d;
      bus.valid   = 1'b1;
      while (bus.ready !== 1'b1 && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      check("push_wait_bound", n < LIMIT, 1'b1);
      edge_n = cyc + 1;
      exp_q.push_back(d);
      @(posedge clk);
   endtask

   task automatic release_bus();
      @(negedge clk);
      bus.valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag, output int lmax);
      int n = 0;
      lmax = 0;
      @(negedge clk);
      while ((busy !== 1'b0 || rx_active) && n < LIMIT) begin
         if (int'(level) > lmax) lmax = int'(level);
         @(negedge clk);
         n++;
      end
      check(tag, n < LIMIT, 1'b1);
   endtask

   task automatic compare_rx(input string tag);
      check({tag, "_count"}, rx_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         check(tag, rx_q[i], exp_q[i]);
      end
      rx_q.delete();
      exp_q.delete();
      rx_start.delete();
   endtask

   task automatic frame_wave(input logic [7:0] d);
      int e;
      int lm;
      push(d, e);
      release_bus();
      check("wave_level", level, 3'd1);
      check("wave_latency_tx", uart_tx, 1'b1);
      for (int t = 1; t <= FRAME_CLKS; t++) begin
         @(negedge clk);
         check("wave_tx", uart_tx, frame_bit(d, (t - 1) / CPB));
         check("wave_busy", busy, 1'b1);
      end
      @(negedge clk);
      check("wave_busy_fall", busy, 1'b0);
      check("wave_idle_tx", uart_tx, 1'b1);
      wait_idle("wave_drain_bound", lm);
      check("wave_start_cycle", (rx_start.size() > 0) ? rx_start[0] : -1, e + 1);
      compare_rx("wave_rx");
   endtask

   initial begin : watchdog
      #3000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int e;
      int e_last;
      int lm;
      int gap;

      // Reset with valid held high: nothing may be enqueued.
      bus.valid   = 1'b1;
      bus.byte_in = 8'hA5;
      rst         = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_tx", uart_tx, 1'b1);
         check("rst_ready", bus.ready, 1'b0);
         check("rst_level", level, 3'd0);
      end
      rst       = 1'b0;
      bus.valid = 1'b0;
      @(negedge clk);
      check("idle_ready", bus.ready, 1'b1);
      check("idle_busy", busy, 1'b0);
      check("idle_level", level, 3'd0);
      check("idle_tx", uart_tx, 1'b1);
      mon_en = 1'b1;

      // Single frames against the ideal waveform.
      frame_wave(8'h41);
      frame_wave(8'h07);

      // Back-to-back pushes on consecutive edges.
      push(8'h55, e);
      push(8'hAA, e);
      push(8'h0F, e);
      release_bus();
      check("b2b_level_peak", level, 3'd2);
      wait_idle("b2b_drain_bound", lm);
      check("b2b_level_max", lm, 2);
      check("b2b_frames", rx_start.size(), 3);
      for (int i = 1; i < rx_start.size(); i++) begin
         check("b2b_gap", rx_start[i] - rx_start[i-1], FRAME_CLKS);
      end
      compare_rx("b2b_rx");

      // Fill the FIFO while the first frame is on the line.
      for (int i = 0; i < 5; i++) push(8'h30 + 8'(i), e);
      @(negedge clk);
      check("full_level", level, 3'd4);
      check("full_ready", bus.ready, 1'b0);
      push(8'h35, e_last);
      release_bus();
      wait_idle("full_drain_bound", lm);
      check("full_level_max", lm, 4);
      check("full_frames", rx_start.size(), 6);
      if (rx_start.size() > 1) begin
         check("full_push_after_pop", e_last, rx_start[1] + 1);
      end
      for (int i = 1; i < rx_start.size(); i++) begin
         check("full_gap", rx_start[i] - rx_start[i-1], FRAME_CLKS);
      end
      compare_rx("full_rx");

      // Reset 40 clocks into the first of two queued frames.
      push(8'hFF, e);
      push(8'hFF, e_last);
      release_bus();
      while (cyc < e + 40) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_tx", uart_tx, 1'b1);
      check("midrst_level", level, 3'd0);
      check("midrst_ready", bus.ready, 1'b0);
      check("midrst_busy", busy, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
         @(negedge clk);
         check("midrst_after_tx", uart_tx, 1'b1);
         check("midrst_after_busy", busy, 1'b0);
      end
      check("midrst_rx_none", rx_q.size(), 0);
      exp_q.delete();
      rx_q.delete();
      rx_start.delete();

      // Random bytes with random idle gaps.
      for (int i = 0; i < 24; i++) begin
         push(8'($urandom), e);
         gap = $urandom_range(0, 3);
         if (gap != 0) begin
            release_bus();
            repeat (gap - 1) @(negedge clk);
         end
      end
      release_bus();
      wait_idle("rand_drain_bound", lm);
      check("rand_level_bound", lm <= FIFO_DEPTH, 1'b1);
      for (int i = 1; i < rx_start.size(); i++) begin
         check("rand_spacing", rx_start[i] - rx_start[i-1] >= FRAME_CLKS, 1'b1);
      end
      compare_rx("rand_rx");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
